// File: rtl/wisc_pkg.sv
// Shared ALU op, flag index and branch condition definitions.
// Also provides the per-op flag update mask.
package wisc_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_PADDSB = 3'b010,
        OP_RED    = 3'b011,
        OP_SLL    = 3'b100,
        OP_SRA    = 3'b101,
        OP_ROR    = 3'b110,
        OP_XOR    = 3'b111
    } alu_op_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        CC_NE     = 3'b000,
        CC_EQ     = 3'b001,
        CC_GT     = 3'b010,
        CC_LT     = 3'b011,
        CC_GE     = 3'b100,
        CC_LE     = 3'b101,
        CC_OV     = 3'b110,
        CC_UNCOND = 3'b111
    } cc_e;

    typedef enum logic {
        BR_IDLE = 1'b0,
        BR_DONE = 1'b1
    } br_state_e;

    function automatic logic [2:0] flag_upd_mask(input logic [2:0] ctl);
        logic [2:0] mask;
        mask = 3'b000;
        unique case (ctl)
            OP_ADD, OP_SUB:                 mask = 3'b111;
            OP_SLL, OP_SRA, OP_ROR, OP_XOR: mask = 3'b100;
            OP_PADDSB, OP_RED:              mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator over {Z,V,N}.
// Purely combinational; shared with the predictor checker.
module cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CC_NE:     taken = ~z;
            CC_EQ:     taken = z;
            CC_GT:     taken = ~z & ~n;
            CC_LT:     taken = n;
            CC_GE:     taken = z | (~z & ~n);
            CC_LE:     taken = n | z;
            CC_OV:     taken = v;
            CC_UNCOND: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// Z/V/N flag register with per-op update masks, same-cycle
// bypass into branch evaluation, and a branch-done tracker.
module flag_unit
    import wisc_pkg::*;
#(
    parameter logic [2:0] RESET_FLAGS = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] alu_ctl,
    input  logic [2:0] alu_flags,
    input  logic       alu_valid,
    input  logic       flush,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    output logic [2:0] flags_q,
    output logic       br_taken,
    output logic       br_taken_q,
    output logic       br_done
);

    logic       we;
    logic [2:0] mask;
    logic [2:0] flags_next;
    logic       cond_true;
    br_state_e  state;

    assign mask = flag_upd_mask(alu_ctl);
    assign we   = alu_valid & ~flush;

    always_comb begin
        flags_next = flags_q;
        for (int i = 0; i < 3; i++) begin
            if (we & mask[i]) begin
                flags_next[i] = alu_flags[i];
            end
        end
    end

    // Branches see this cycle's flag write, masked bits only.
    cond_eval u_cond_eval (
        .flags (flags_next),
        .cond  (br_cond),
        .taken (cond_true)
    );

    assign br_taken = br_valid & cond_true;
    assign br_done  = (state == BR_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q    <= RESET_FLAGS;
            br_taken_q <= 1'b0;
            state      <= BR_IDLE;
        end else begin
            flags_q    <= flags_next;
            br_taken_q <= br_taken;
            unique case (state)
                BR_IDLE: state <= br_valid ? BR_DONE : BR_IDLE;
                BR_DONE: state <= br_valid ? BR_DONE : BR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: masks, bypass, flush,
// reset and a full flag x condition sweep.
module tb_flag_unit;

    logic       clk;
    logic       rst_n;
    logic [2:0] alu_ctl;
    logic [2:0] alu_flags;
    logic       alu_valid;
    logic       flush;
    logic       br_valid;
    logic [2:0] br_cond;
    logic [2:0] flags_q;
    logic       br_taken;
    logic       br_taken_q;
    logic       br_done;

    int n_vec = 0;
    int n_err = 0;

    flag_unit #(.RESET_FLAGS(3'b000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_ctl    (alu_ctl),
        .alu_flags  (alu_flags),
        .alu_valid  (alu_valid),
        .flush      (flush),
        .br_valid   (br_valid),
        .br_cond    (br_cond),
        .flags_q    (flags_q),
        .br_taken   (br_taken),
        .br_taken_q (br_taken_q),
        .br_done    (br_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [2:0] obs,
                       input logic [2:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [2:0] ctl, input logic [2:0] f);
        alu_valid = 1'b1;
        alu_ctl   = ctl;
        alu_flags = f;
    endtask

    function automatic logic ref_cc(input logic [2:0] f, input int c);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || (!z && !n);
            5: return n || z;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        logic exp_t;
        rst_n     = 1'b0;
        flush     = 1'b0;
        br_valid  = 1'b1;
        br_cond   = 3'b111;
        alu(3'b000, 3'b111);
        tick();
        tick();
        chk("reset_flags", flags_q, 3'b000);
        chk("reset_done", {2'b00, br_done}, 3'b000);
        chk("reset_tq", {2'b00, br_taken_q}, 3'b000);

        rst_n     = 1'b1;
        alu_valid = 1'b0;
        br_valid  = 1'b0;
        tick();

        alu(3'b001, 3'b011);
        tick();
        chk("sub_flags", flags_q, 3'b011);
        alu(3'b111, 3'b100);
        tick();
        chk("xor_flags", flags_q, 3'b111);

        alu(3'b000, 3'b010);
        tick();
        chk("preload_010", flags_q, 3'b010);
        alu(3'b010, 3'b101);
        tick();
        chk("paddsb_hold", flags_q, 3'b010);
        alu(3'b011, 3'b111);
        tick();
        chk("red_hold", flags_q, 3'b010);

        alu(3'b000, 3'b000);
        tick();
        chk("preload_000", flags_q, 3'b000);
        alu(3'b000, 3'b100);
        br_valid = 1'b1;
        br_cond  = 3'b001;
        #1;
        chk("bypass_eq", {2'b00, br_taken}, 3'b001);
        tick();
        chk("bypass_flags", flags_q, 3'b100);
        chk("bypass_tq", {2'b00, br_taken_q}, 3'b001);
        chk("bypass_done", {2'b00, br_done}, 3'b001);
        alu_valid = 1'b0;
        br_valid  = 1'b0;
        #1;
        chk("idle_taken", {2'b00, br_taken}, 3'b000);
        tick();
        chk("idle_done", {2'b00, br_done}, 3'b000);
        chk("idle_tq", {2'b00, br_taken_q}, 3'b000);

        flush = 1'b1;
        alu(3'b000, 3'b010);
        br_valid = 1'b1;
        br_cond  = 3'b110;
        #1;
        chk("flush_taken", {2'b00, br_taken}, 3'b000);
        tick();
        chk("flush_flags", flags_q, 3'b100);
        chk("flush_tq", {2'b00, br_taken_q}, 3'b000);
        flush    = 1'b0;
        br_valid = 1'b0;

        alu(3'b000, 3'b110);
        tick();
        chk("preload_110", flags_q, 3'b110);
        alu(3'b111, 3'b001);
        br_valid = 1'b1;
        br_cond  = 3'b110;
        #1;
        chk("mask_byp_ov", {2'b00, br_taken}, 3'b001);
        br_cond = 3'b011;
        #1;
        chk("mask_byp_lt", {2'b00, br_taken}, 3'b000);
        br_cond = 3'b000;
        #1;
        chk("mask_byp_ne", {2'b00, br_taken}, 3'b001);
        tick();
        chk("mask_flags", flags_q, 3'b010);

        alu_valid = 1'b0;
        br_valid  = 1'b1;
        br_cond   = 3'b111;
        rst_n     = 1'b0;
        tick();
        chk("midrst_flags", flags_q, 3'b000);
        chk("midrst_done", {2'b00, br_done}, 3'b000);
        chk("midrst_tq", {2'b00, br_taken_q}, 3'b000);
        rst_n    = 1'b1;
        br_valid = 1'b0;
        tick();
        chk("midrst_after", {2'b00, br_done}, 3'b000);

        for (int f = 0; f < 8; f++) begin
            br_valid = 1'b0;
            alu(3'b000, 3'(f));
            tick();
            chk("sweep_preload", flags_q, 3'(f));
            alu_valid = 1'b0;
            for (int c = 0; c < 8; c++) begin
                br_valid = 1'b1;
                br_cond  = 3'(c);
                exp_t    = ref_cc(3'(f), c);
                #1;
                chk($sformatf("cc f=%0d c=%0d", f, c),
                    {2'b00, br_taken}, {2'b00, exp_t});
                tick();
                chk("sweep_tq", {2'b00, br_taken_q}, {2'b00, exp_t});
                chk("sweep_done", {2'b00, br_done}, 3'b001);
            end
            br_valid = 1'b0;
            tick();
            chk("sweep_drop", {2'b00, br_done}, 3'b000);
            chk("sweep_tq0", {2'b00, br_taken_q}, 3'b000);
            chk("sweep_keep", flags_q, 3'(f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
